// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS main controller.
// Sequences FETCH -> DECODE -> execute/memory/writeback from the IR op/funct
// fields and drives every datapath enable and mux select. Memory accesses
// stall on i_mem_ready and trap after MEM_TIMEOUT cycles of waiting. Illegal
// op/funct codes also trap. TRAP is left only through reset.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_op, i_funct       IR[31:26], IR[5:0]
//   i_zero              ALU zero flag (consumed by the datapath PC gating)
//   i_mem_ready         memory completes the current access this cycle
//   o_ir_write .. o_pc_source   datapath enables and mux selects
//   o_state             current state encoding (debug)
//   o_trap, o_trap_cause  sticky error flag and its cause (01 illegal, 10 timeout)
module mips_mc_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter logic [5:0]  OP_MOVE     = 6'b001111
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic       o_pc_write_cond,
  output logic       o_i_or_d,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_reg_write,
  output logic       o_reg_dst,
  output logic [1:0] o_mem_to_reg,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_pc_source,
  output logic [3:0] o_state,
  output logic       o_trap,
  output logic [1:0] o_trap_cause
);

  localparam int unsigned CNT_W = 8;
  // Last counter value before the timeout fires; reached after MEM_TIMEOUT
  // consecutive not-ready cycles in one wait state.
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXE   = 4'd7,
    S_RWB    = 4'd8,
    S_BEQ    = 4'd9,
    S_JMP    = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_MOVWB  = 4'd13,
    S_TRAP   = 4'd15
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_nxt;
  logic [1:0]       r_trap_cause;
  logic [1:0]       w_cause_nxt;
  logic             w_mem_wait;
  logic             w_funct_ok;

  // The zero flag only gates the PC load inside the datapath.
  logic w_unused;
  assign w_unused = i_zero;

  // Legal R-type functs: add, sub, and, or, slt.
  always_comb begin
    unique case (i_funct)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: w_funct_ok = 1'b1;
      default:                           w_funct_ok = 1'b0;
    endcase
  end

  // State, wait counter and trap cause registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= '0;
      r_trap_cause <= 2'b00;
    end else begin
      r_state      <= w_next;
      r_wait_cnt   <= w_wait_nxt;
      r_trap_cause <= w_cause_nxt;
    end
  end

  // Next state and Moore outputs; ir_write/pc_write in FETCH follow mem_ready.
  always_comb begin
    w_next          = r_state;
    w_cause_nxt     = r_trap_cause;
    w_mem_wait      = 1'b0;
    o_ir_write      = 1'b0;
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_i_or_d        = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_reg_write     = 1'b0;
    o_reg_dst       = 1'b0;
    o_mem_to_reg    = 2'b00;
    o_alu_src_a     = 1'b0;
    o_alu_src_b     = 2'b00;
    o_alu_op        = 2'b00;
    o_pc_source     = 2'b00;

    case (r_state)
      S_IDLE: w_next = S_FETCH;

      S_FETCH: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = 2'b01;
        w_mem_wait  = 1'b1;
        if (i_mem_ready) begin
          o_ir_write = 1'b1;
          o_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end

      S_DECODE: begin
        o_alu_src_b = 2'b11;
        if (i_op == OP_RTYPE) begin
          if (w_funct_ok) begin
            w_next = S_REXE;
          end else begin
            w_next      = S_TRAP;
            w_cause_nxt = CAUSE_ILLEGAL;
          end
        end else if (i_op == OP_LW || i_op == OP_SW) begin
          w_next = S_MEMADR;
        end else if (i_op == OP_BEQ) begin
          w_next = S_BEQ;
        end else if (i_op == OP_J) begin
          w_next = S_JMP;
        end else if (i_op == OP_ADDI) begin
          w_next = S_ADDIEX;
        end else if (i_op == OP_MOVE) begin
          w_next = S_MOVWB;
        end else begin
          w_next      = S_TRAP;
          w_cause_nxt = CAUSE_ILLEGAL;
        end
      end

      S_MEMADR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
        w_next      = (i_op == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        o_mem_read = 1'b1;
        o_i_or_d   = 1'b1;
        w_mem_wait = 1'b1;
        if (i_mem_ready) w_next = S_MEMWB;
      end

      S_MEMWB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 2'b01;
        w_next       = S_FETCH;
      end

      S_MEMWR: begin
        o_mem_write = 1'b1;
        o_i_or_d    = 1'b1;
        w_mem_wait  = 1'b1;
        if (i_mem_ready) w_next = S_FETCH;
      end

      S_REXE: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = 2'b10;
        w_next      = S_RWB;
      end

      S_RWB: begin
        o_reg_write = 1'b1;
        o_reg_dst   = 1'b1;
        w_next      = S_FETCH;
      end

      S_BEQ: begin
        o_alu_src_a     = 1'b1;
        o_alu_op        = 2'b01;
        o_pc_write_cond = 1'b1;
        o_pc_source     = 2'b01;
        w_next          = S_FETCH;
      end

      S_JMP: begin
        o_pc_write  = 1'b1;
        o_pc_source = 2'b10;
        w_next      = S_FETCH;
      end

      S_ADDIEX: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
        w_next      = S_ADDIWB;
      end

      S_ADDIWB: begin
        o_reg_write = 1'b1;
        w_next      = S_FETCH;
      end

      S_MOVWB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 2'b10;
        w_next       = S_FETCH;
      end

      S_TRAP: w_next = S_TRAP;

      default: w_next = S_IDLE;
    endcase

    // A ready in the limit cycle wins; only a still-pending access traps.
    if (w_mem_wait && !i_mem_ready && r_wait_cnt == CNT_LIMIT) begin
      w_next      = S_TRAP;
      w_cause_nxt = CAUSE_TIMEOUT;
    end
  end

  // Count only while holding in a wait state; any transition clears it.
  always_comb begin
    w_wait_nxt = '0;
    if (w_mem_wait && w_next == r_state) w_wait_nxt = r_wait_cnt + CNT_W'(1);
  end

  assign o_state      = 4'(r_state);
  assign o_trap       = (r_state == S_TRAP);
  assign o_trap_cause = r_trap_cause;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: state walk and full control vector per cycle.
module tb_mips_mc_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       ir_write, pc_write, pc_write_cond, i_or_d;
  logic       mem_read, mem_write, reg_write, reg_dst;
  logic [1:0] mem_to_reg, alu_src_b, alu_op, pc_source;
  logic       alu_src_a;
  logic [3:0] state;
  logic       trap;
  logic [1:0] trap_cause;

  int n_checks = 0;
  int n_errors = 0;

  mips_mc_ctrl #(.MEM_TIMEOUT(4), .OP_MOVE(6'b001111)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_op           (op),
    .i_funct        (funct),
    .i_zero         (zero),
    .i_mem_ready    (mem_ready),
    .o_ir_write     (ir_write),
    .o_pc_write     (pc_write),
    .o_pc_write_cond(pc_write_cond),
    .o_i_or_d       (i_or_d),
    .o_mem_read     (mem_read),
    .o_mem_write    (mem_write),
    .o_reg_write    (reg_write),
    .o_reg_dst      (reg_dst),
    .o_mem_to_reg   (mem_to_reg),
    .o_alu_src_a    (alu_src_a),
    .o_alu_src_b    (alu_src_b),
    .o_alu_op       (alu_op),
    .o_pc_source    (pc_source),
    .o_state        (state),
    .o_trap         (trap),
    .o_trap_cause   (trap_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] ctrl;
  assign ctrl = {ir_write, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                 reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source};

  function automatic logic [16:0] mk(input logic ir, input logic pcw, input logic pcc,
                                     input logic iod, input logic mr, input logic mw,
                                     input logic rw, input logic rd, input logic [1:0] m2r,
                                     input logic asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic [1:0] ps);
    return {ir, pcw, pcc, iod, mr, mw, rw, rd, m2r, asa, asb, aop, ps};
  endfunction

  logic [16:0] c_z, c_f1, c_f0, c_dec, c_adr, c_rd, c_mwb, c_wr;
  logic [16:0] c_rex, c_rwb, c_beq, c_jmp, c_aex, c_awb, c_mov;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cyc(input string tag, input logic [3:0] st, input logic [16:0] c);
    #1;
    check({tag, "/state"}, 32'(state), 32'(st));
    check({tag, "/ctrl"}, 32'(ctrl), 32'(c));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    c_z   = '0;
    c_f1  = mk(1,1,0,0,1,0,0,0,2'b00,0,2'b01,2'b00,2'b00);
    c_f0  = mk(0,0,0,0,1,0,0,0,2'b00,0,2'b01,2'b00,2'b00);
    c_dec = mk(0,0,0,0,0,0,0,0,2'b00,0,2'b11,2'b00,2'b00);
    c_adr = mk(0,0,0,0,0,0,0,0,2'b00,1,2'b10,2'b00,2'b00);
    c_rd  = mk(0,0,0,1,1,0,0,0,2'b00,0,2'b00,2'b00,2'b00);
    c_mwb = mk(0,0,0,0,0,0,1,0,2'b01,0,2'b00,2'b00,2'b00);
    c_wr  = mk(0,0,0,1,0,1,0,0,2'b00,0,2'b00,2'b00,2'b00);
    c_rex = mk(0,0,0,0,0,0,0,0,2'b00,1,2'b00,2'b10,2'b00);
    c_rwb = mk(0,0,0,0,0,0,1,1,2'b00,0,2'b00,2'b00,2'b00);
    c_beq = mk(0,0,1,0,0,0,0,0,2'b00,1,2'b00,2'b01,2'b01);
    c_jmp = mk(0,1,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b10);
    c_aex = mk(0,0,0,0,0,0,0,0,2'b00,1,2'b10,2'b00,2'b00);
    c_awb = mk(0,0,0,0,0,0,1,0,2'b00,0,2'b00,2'b00,2'b00);
    c_mov = mk(0,0,0,0,0,0,1,0,2'b10,0,2'b00,2'b00,2'b00);

    rst_n = 1'b0; mem_ready = 1'b1; op = 6'h00; funct = 6'h20; zero = 1'b0;
    step(); step();
    expect_cyc("reset", 4'd0, c_z);
    check("reset/trap", 32'(trap), 32'd0);
    check("reset/cause", 32'(trap_cause), 32'd0);

    // R-type add: 0,1,2,7,8,1
    rst_n = 1'b1;
    expect_cyc("idle", 4'd0, c_z);
    step(); expect_cyc("r_fetch", 4'd1, c_f1);
    step(); expect_cyc("r_decode", 4'd2, c_dec);
    step(); expect_cyc("r_exe", 4'd7, c_rex);
    step(); expect_cyc("r_wb", 4'd8, c_rwb);
    step(); expect_cyc("r_fetch2", 4'd1, c_f1);

    // lw with 3 stall cycles; ready arrives exactly in the limit cycle
    op = 6'h23;
    step(); expect_cyc("lw_decode", 4'd2, c_dec);
    step(); expect_cyc("lw_adr", 4'd3, c_adr);
    step(); mem_ready = 1'b0;
    expect_cyc("lw_rd0", 4'd4, c_rd);
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 2) mem_ready = 1'b1;
      expect_cyc("lw_rd_stall", 4'd4, c_rd);
    end
    step(); expect_cyc("lw_wb", 4'd5, c_mwb);
    step(); expect_cyc("lw_fetch", 4'd1, c_f1);

    // beq taken and not taken: controls identical
    for (int z = 1; z >= 0; z--) begin
      op = 6'h04; zero = z[0];
      step(); expect_cyc("beq_decode", 4'd2, c_dec);
      step(); expect_cyc("beq", 4'd9, c_beq);
      step(); expect_cyc("beq_fetch", 4'd1, c_f1);
    end

    // addi
    op = 6'h08;
    step(); expect_cyc("addi_decode", 4'd2, c_dec);
    step(); expect_cyc("addi_ex", 4'd11, c_aex);
    step(); expect_cyc("addi_wb", 4'd12, c_awb);
    step(); expect_cyc("addi_fetch", 4'd1, c_f1);

    // move immediate
    op = 6'h0F;
    step(); expect_cyc("mov_decode", 4'd2, c_dec);
    step(); expect_cyc("mov_wb", 4'd13, c_mov);
    step(); expect_cyc("mov_fetch", 4'd1, c_f1);

    // FETCH stall with ready arriving in the 4th wait cycle, then j
    mem_ready = 1'b0;
    expect_cyc("fw_0", 4'd1, c_f0);
    step(); expect_cyc("fw_1", 4'd1, c_f0);
    step(); expect_cyc("fw_2", 4'd1, c_f0);
    step(); mem_ready = 1'b1;
    expect_cyc("fw_3_ready", 4'd1, c_f1);
    op = 6'h02;
    step(); expect_cyc("j_decode", 4'd2, c_dec);
    check("j/trap", 32'(trap), 32'd0);
    step(); expect_cyc("j", 4'd10, c_jmp);
    step(); expect_cyc("j_fetch", 4'd1, c_f1);

    // sw stalled in MEMWR, reset asserted mid-cycle
    op = 6'h2B;
    step(); expect_cyc("sw_decode", 4'd2, c_dec);
    step(); expect_cyc("sw_adr", 4'd3, c_adr);
    step(); mem_ready = 1'b0;
    expect_cyc("sw_wr0", 4'd6, c_wr);
    step(); expect_cyc("sw_wr1", 4'd6, c_wr);
    #2 rst_n = 1'b0;
    #1;
    check("sw_rst/state", 32'(state), 32'd0);
    check("sw_rst/mem_write", 32'(mem_write), 32'd0);
    check("sw_rst/ctrl", 32'(ctrl), 32'd0);
    step(); mem_ready = 1'b1; rst_n = 1'b1;
    expect_cyc("sw_rst_idle", 4'd0, c_z);
    step(); expect_cyc("sw_rst_fetch", 4'd1, c_f1);

    // FETCH timeout: 4 not-ready cycles then TRAP, cause 10
    mem_ready = 1'b0;
    expect_cyc("to_0", 4'd1, c_f0);
    step(); expect_cyc("to_1", 4'd1, c_f0);
    step(); expect_cyc("to_2", 4'd1, c_f0);
    step(); expect_cyc("to_3", 4'd1, c_f0);
    step(); expect_cyc("to_trap", 4'd15, c_z);
    check("to/trap", 32'(trap), 32'd1);
    check("to/cause", 32'(trap_cause), 32'd2);

    // Illegal opcode: TRAP cause 01, held for 20 cycles with mem_ready toggling
    rst_n = 1'b0;
    #1;
    check("trap_rst/state", 32'(state), 32'd0);
    check("trap_rst/cause", 32'(trap_cause), 32'd0);
    step(); rst_n = 1'b1; mem_ready = 1'b1; op = 6'h3F;
    step(); expect_cyc("ill_fetch", 4'd1, c_f1);
    step(); expect_cyc("ill_decode", 4'd2, c_dec);
    step(); expect_cyc("ill_trap", 4'd15, c_z);
    check("ill/trap", 32'(trap), 32'd1);
    check("ill/cause", 32'(trap_cause), 32'd1);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      step(); expect_cyc("ill_hold", 4'd15, c_z);
    end
    check("ill_hold/cause", 32'(trap_cause), 32'd1);

    // Illegal R-type funct
    rst_n = 1'b0;
    step(); rst_n = 1'b1; mem_ready = 1'b1; op = 6'h00; funct = 6'h21;
    step(); expect_cyc("badf_fetch", 4'd1, c_f1);
    step(); expect_cyc("badf_decode", 4'd2, c_dec);
    step(); expect_cyc("badf_trap", 4'd15, c_z);
    check("badf/cause", 32'(trap_cause), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multi-cycle MIPS main controller.
- Sequences instruction fetch into the instruction register, then decode, execute, memory and writeback, using the op/funct fields the instruction register splits out.
- Drives every datapath enable and mux select, and stalls on a ready-handshaked unified memory.
- Traps on illegal opcodes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles a memory request may wait for mem_ready before trap (1..255).
- OP_MOVE, 6'b001111: opcode of the move-immediate instruction (writes IR[15:0], zero-extended, to rt).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]; only R-type 6'h20/22/24/25/2A are legal
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read/write this cycle
- ir_write  out  1  load instruction register
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero
- i_or_d  out  1  memory address: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  register file write
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  2  writeback source: 00=ALUOut, 01=MDR, 10=move_data
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_op  out  2  00=add, 01=sub, 10=funct, 11=reserved
- pc_source  out  2  00=ALU, 01=ALUOut, 10=jump target
- state  out  4  current state encoding (debug)
- trap  out  1  sticky error flag
- trap_cause  out  2  01=illegal op/funct, 10=memory timeout

Behaviour:
- Async reset (rst_n=0): state=IDLE, wait counter=0, trap=0, trap_cause=00. Every output is 0 while in reset and in IDLE.
- State encoding:
  - IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, REXE=7
  - RWB=8, BEQ=9, JMP=10, ADDIEX=11, ADDIWB=12, MOVWB=13, TRAP=15
- IDLE -> FETCH unconditionally, one cycle after reset release.
- Outputs are Moore on state, except ir_write/pc_write in FETCH, which are qualified by mem_ready. Any signal not listed below is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - mem_ready=1: ir_write=1, pc_write=1 in the same cycle; next state DECODE.
  - mem_ready=0: stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by op:
  - 000000 with legal funct -> REXE; illegal funct -> TRAP, cause 01
  - 100011 (lw) / 101011 (sw) -> MEMADR
  - 000100 -> BEQ
  - 000010 -> JMP
  - 001000 -> ADDIEX
  - OP_MOVE -> MOVWB
  - any other op -> TRAP, cause 01
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEMRD (lw) or MEMWR (sw); op is held stable by the IR.
- MEMRD: mem_read=1, i_or_d=1. Stay until mem_ready, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=01 -> FETCH.
- MEMWR: mem_write=1, i_or_d=1. Stay until mem_ready, then FETCH.
- REXE: alu_src_a=1, alu_src_b=00, alu_op=10 -> RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=00 -> FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
- JMP: pc_write=1, pc_source=10 -> FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=00 -> FETCH.
- MOVWB: reg_write=1, reg_dst=0, mem_to_reg=10 -> FETCH.
- Wait counter (8 bit):
  - Cleared on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle the state holds with mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready=0 -> TRAP, cause 10.
  - mem_ready=1 in the same cycle as the limit is reached wins: normal transition.
- TRAP: all control outputs 0, trap=1, trap_cause held. Exit only via reset.
- Reset mid-operation, in any state including a memory wait: immediate return to IDLE with all outputs 0. No partial write may be completed.
- Cycle counts with mem_ready tied high:
  - lw 5 cycles; sw 4; R-type 4; addi 4; beq 3; j 3; move 3.

Test Plan:
- rst_n low, then release; mem_ready=1, op=000000, funct=6'h20 -> states 0,1,2,7,8,1. ir_write and pc_write high at the first FETCH. reg_write=1 and reg_dst=1 in RWB.
- lw (op=100011), mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles with mem_read=1, i_or_d=1. MEMWB asserts reg_write with mem_to_reg=01. Total 8 cycles from FETCH to next FETCH.
- beq (op=000100) with zero=1, then with zero=0 -> pc_write_cond=1, pc_source=01 in BEQ both times; returns to FETCH after 3 cycles.
- op=6'h3F -> DECODE to TRAP; trap=1, trap_cause=01, all controls 0, and it stays for 20 cycles despite mem_ready toggling.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP after 4 wait cycles, cause 10. Repeat with mem_ready=1 on the 4th cycle -> DECODE, no trap.
- sw stalling in MEMWR, assert rst_n=0 -> outputs 0 asynchronously, state=0, mem_write=0; after release, normal FETCH.
